mc_datapath: RTL
================

# mc_datapath

Multi-cycle, parametrised successor to the 4-bit single-cycle datapath. Fetches instructions from an external instruction memory, decodes them, and executes them through a FETCH/DECODE/EXEC/WB state machine over a generic-width register file. It adds run/idle control, a conditional branch, HALT, and a per-instruction retire strobe. It sits between the instruction ROM and the top-level debug outputs.

## Interface
- DATA_W, 4, register and ALU width in bits (≥ RS)
- NREG, 4, number of registers; a power of two, ≥ 2; RS = $clog2(NREG)
- PC_W, 4, program-counter width; instruction-memory depth is 2^PC_W
- INS_W, 3+2*RS+DATA_W (derived, not overridable), instruction width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  start/continue request
- imem_addr  out  PC_W  instruction address; equals current PC
- imem_data  in  INS_W  instruction word; combinational memory read of imem_addr
- busy  out  1  high in FETCH/DECODE/EXEC/WB
- halted  out  1  high in HALT state
- retire  out  1  one-cycle pulse in WB of each executed instruction
- regs_flat  out  NREG*DATA_W  register contents; R[i] at [i*DATA_W +: DATA_W]

## Operation
- Instruction fields, MSB first: op[2:0], W sel (RS), A sel (RS), imm (DATA_W). B sel = imm[RS-1:0].
- Opcodes:
  - 000 ADD: R[W]=R[A]+R[B]
  - 001 SUB: R[W]=R[A]-R[B]
  - 010 LDI: R[W]=imm
  - 011 BEQZ: if R[A]==0, PC=imm[PC_W-1:0] (zero-extended if PC_W > DATA_W); no register write
  - 100 AND
  - 101 OR
  - 110 NOP
  - 111 HALT
- Arithmetic is modulo 2^DATA_W; carry and borrow are discarded.
- States:
  - IDLE: run=1 → FETCH.
  - FETCH: latch IR ← imem_data → DECODE.
  - DECODE: latch opA ← R[A], opB ← R[B] → EXEC.
  - EXEC: latch RES ← ALU/imm result and the branch-taken flag → WB, or → HALT if op=HALT.
  - WB: write R[W] for ADD/SUB/LDI/AND/OR; update PC; pulse retire; then → FETCH if run=1, else → IDLE.
- PC update: branch-taken → target; otherwise PC+1, wrapping from 2^PC_W−1 to 0.
- HALT is sticky until rst_n. HALT does not retire, and the PC stays at the HALT address.
- run is sampled only in IDLE and WB. Deasserting run mid-instruction lets that instruction complete.
- R0 is an ordinary writable register.

## Timing
- Reset (asynchronous): state=IDLE, PC=0, all registers=0, IR=0, busy=0, halted=0, retire=0, imem_addr=0.
- Four cycles per instruction. The first retire comes 5 cycles after run is sampled high in IDLE: one cycle to leave IDLE, then FETCH, DECODE, EXEC, WB.
- A register write in WB is visible in regs_flat the next cycle and is read correctly by the next instruction's DECODE.
- An rst_n assertion mid-instruction aborts it immediately. No partial write occurs.
- All outputs are registered or decoded from registered state only.

## Configuration
- MC_DATAPATH_BRANCH_EN defined: BEQZ is implemented as described above.
- Not defined: opcode 011 behaves as NOP (PC+1, retire pulses, no write), and the zero-compare logic is removed.

## Structure
- mc_datapath_pkg holds:
  - opcode enum (OP_ADD … OP_HALT)
  - state enum (ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_WB, ST_HALT)
  - field-position localparams as functions of RS and DATA_W
- One sub-module, mc_alu, parametrised by DATA_W: combinational ADD/SUB/AND/OR selected by op[1:0] plus the zero flag.
- The register file stays inline as an array reset by rst_n.

## Test plan
- Reset then idle: rst_n low, then high with run=0 for 10 cycles → IDLE holds, busy=0, PC=0, regs_flat=0.
- LDI R1,5; LDI R2,3; ADD R3,R1,R2; SUB R0,R2,R1; HALT, with run=1 → R3=8, R0=14 (4'hE), 4 retire pulses spaced 4 cycles apart, then halted=1 and PC stays at 4.
- Wrap: LDI R1,15; LDI R2,1; ADD R1,R1,R2 → R1=0. Sixteen NOPs from PC 0 → PC wraps 15→0.
- Branch (macro defined): LDI R1,0; BEQZ R1,6 → next imem_addr=6. With R1=2 → imem_addr=2. With the macro undefined → always PC+1.
- Run drop: deassert run during EXEC of an ADD → the ADD still retires and the state goes to IDLE. Reasserting run resumes at the next PC.
- Mid-op reset: pulse rst_n low during WB of LDI R2,9 → R2=0, PC=0, state=IDLE. Repeat with DATA_W=8, NREG=8 and LDI R7,200; ADD R7,R7,R7 → R7=144.

Source files
------------

// File: rtl/mc_datapath_pkg.sv
// mc_datapath_pkg: shared types and instruction-field helpers for mc_datapath.
//   opcode_e  : 3-bit opcode set (OP_ADD .. OP_HALT)
//   state_e   : multi-cycle controller states
//   *_lsb_f   : instruction field positions as functions of RS and DATA_W
//   alu_sel_f : maps an arithmetic/logic opcode onto the 2-bit mc_alu select
package mc_datapath_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_LDI  = 3'b010,
    OP_BEQZ = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_NOP  = 3'b110,
    OP_HALT = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam int OP_W = 3;

  // Instruction layout, MSB first: op | W sel | A sel | imm. imm sits at bit 0.
  function automatic int a_lsb_f(input int data_w);
    return data_w;
  endfunction

  function automatic int w_lsb_f(input int rs, input int data_w);
    return data_w + rs;
  endfunction

  function automatic int op_lsb_f(input int rs, input int data_w);
    return data_w + 2 * rs;
  endfunction

  // ADD/SUB/AND/OR differ in op[2] and op[0]; op[1] is zero for all four.
  function automatic logic [1:0] alu_sel_f(input opcode_e op);
    return {op[2], op[0]};
  endfunction

endpackage

// File: rtl/mc_datapath_alu.sv
// mc_alu: combinational ALU for mc_datapath.
//   op     in  2       00 ADD, 01 SUB, 10 AND, 11 OR (modulo 2^DATA_W)
//   a, b   in  DATA_W  operands
//   result out DATA_W  selected result
//   zero   out 1       a == 0; tied low unless MC_DATAPATH_BRANCH_EN is defined
module mc_alu #(
  parameter int DATA_W = 4
) (
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  // Operation select; carry and borrow fall off the top.
  always_comb begin
    result = {DATA_W{1'b0}};
    case (op)
      2'b00:   result = a + b;
      2'b01:   result = a - b;
      2'b10:   result = a & b;
      2'b11:   result = a | b;
      default: result = {DATA_W{1'b0}};
    endcase
  end

`ifdef MC_DATAPATH_BRANCH_EN
  assign zero = (a == {DATA_W{1'b0}});
`else
  assign zero = 1'b0;
`endif

endmodule

// File: rtl/mc_datapath.sv
// mc_datapath: multi-cycle FETCH/DECODE/EXEC/WB datapath over an NREG x DATA_W
// register file, fetching from an external combinational instruction memory.
//   clk, rst_n  clock, asynchronous active-low reset
//   run         start/continue request, sampled in IDLE and WB only
//   imem_addr   instruction address (current PC)
//   imem_data   instruction word for imem_addr
//   busy        high in FETCH/DECODE/EXEC/WB
//   halted      high once HALT executes (sticky until reset)
//   retire      one-cycle pulse in WB of each executed instruction
//   regs_flat   register contents, R[i] at [i*DATA_W +: DATA_W]
// Build option: MC_DATAPATH_BRANCH_EN enables BEQZ; otherwise opcode 011 is a NOP.
module mc_datapath
  import mc_datapath_pkg::*;
#(
  parameter  int DATA_W = 4,
  parameter  int NREG   = 4,
  parameter  int PC_W   = 4,
  localparam int RS     = $clog2(NREG),
  localparam int INS_W  = 3 + 2 * RS + DATA_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  output logic [PC_W-1:0]        imem_addr,
  input  logic [INS_W-1:0]       imem_data,
  output logic                   busy,
  output logic                   halted,
  output logic                   retire,
  output logic [NREG*DATA_W-1:0] regs_flat
);

  localparam int A_LSB  = a_lsb_f(DATA_W);
  localparam int W_LSB  = w_lsb_f(RS, DATA_W);
  localparam int OP_LSB = op_lsb_f(RS, DATA_W);

`ifdef MC_DATAPATH_BRANCH_EN
  localparam logic BRANCH_EN = 1'b1;
`else
  localparam logic BRANCH_EN = 1'b0;
`endif

  state_e            state_r;
  logic [PC_W-1:0]   pc_r;
  logic [INS_W-1:0]  ir_r;
  logic [DATA_W-1:0] opa_r;
  logic [DATA_W-1:0] opb_r;
  logic [DATA_W-1:0] res_r;
  logic              taken_r;
  logic              busy_r;
  logic              halted_r;
  logic              retire_r;
  logic [DATA_W-1:0] regs_r [NREG];

  opcode_e           op_s;
  logic [RS-1:0]     w_sel_s;
  logic [RS-1:0]     a_sel_s;
  logic [RS-1:0]     b_sel_s;
  logic [DATA_W-1:0] imm_s;
  logic [PC_W-1:0]   target_s;
  logic [DATA_W-1:0] alu_res_s;
  logic              alu_zero_s;
  logic [DATA_W-1:0] res_s;
  logic              taken_s;
  logic              wr_en_s;

  assign op_s    = opcode_e'(ir_r[OP_LSB +: OP_W]);
  assign w_sel_s = ir_r[W_LSB +: RS];
  assign a_sel_s = ir_r[A_LSB +: RS];
  assign imm_s   = ir_r[DATA_W-1:0];
  assign b_sel_s = imm_s[RS-1:0];

  // Branch target is imm truncated or zero-extended to the PC width.
  generate
    if (PC_W > DATA_W) begin : g_tgt_ext
      assign target_s = {{(PC_W - DATA_W){1'b0}}, imm_s};
    end else begin : g_tgt_trunc
      assign target_s = imm_s[PC_W-1:0];
    end
  endgenerate

  mc_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (alu_sel_f(op_s)),
    .a      (opa_r),
    .b      (opb_r),
    .result (alu_res_s),
    .zero   (alu_zero_s)
  );

  // Per-opcode result source, write enable and branch decision.
  always_comb begin
    res_s   = alu_res_s;
    taken_s = 1'b0;
    wr_en_s = 1'b0;
    case (op_s)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        res_s   = alu_res_s;
        wr_en_s = 1'b1;
      end
      OP_LDI: begin
        res_s   = imm_s;
        wr_en_s = 1'b1;
      end
      OP_BEQZ: taken_s = BRANCH_EN & alu_zero_s;
      default: res_s   = alu_res_s;
    endcase
  end

  // Controller FSM with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      pc_r     <= {PC_W{1'b0}};
      ir_r     <= {INS_W{1'b0}};
      opa_r    <= {DATA_W{1'b0}};
      opb_r    <= {DATA_W{1'b0}};
      res_r    <= {DATA_W{1'b0}};
      taken_r  <= 1'b0;
      busy_r   <= 1'b0;
      halted_r <= 1'b0;
      retire_r <= 1'b0;
    end else begin
      retire_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (run) begin
            state_r <= ST_FETCH;
            busy_r  <= 1'b1;
          end
        end
        ST_FETCH: begin
          ir_r    <= imem_data;
          state_r <= ST_DECODE;
        end
        ST_DECODE: begin
          opa_r   <= regs_r[a_sel_s];
          opb_r   <= regs_r[b_sel_s];
          state_r <= ST_EXEC;
        end
        ST_EXEC: begin
          res_r   <= res_s;
          taken_r <= taken_s;
          if (op_s == OP_HALT) begin
            // PC is left pointing at the HALT instruction.
            state_r  <= ST_HALT;
            busy_r   <= 1'b0;
            halted_r <= 1'b1;
          end else begin
            state_r  <= ST_WB;
            retire_r <= 1'b1;
          end
        end
        ST_WB: begin
          pc_r <= taken_r ? target_s : (pc_r + {{(PC_W - 1){1'b0}}, 1'b1});
          if (run) begin
            state_r <= ST_FETCH;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_HALT: state_r <= ST_HALT;
        default: begin
          state_r  <= ST_IDLE;
          busy_r   <= 1'b0;
          halted_r <= 1'b0;
        end
      endcase
    end
  end

  // Register file; written only at the end of WB so a reset during WB leaves it clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if ((state_r == ST_WB) && wr_en_s) begin
      regs_r[w_sel_s] <= res_r;
    end
  end

  generate
    for (genvar g = 0; g < NREG; g++) begin : g_flat
      assign regs_flat[g*DATA_W +: DATA_W] = regs_r[g];
    end
  endgenerate

  assign imem_addr = pc_r;
  assign busy      = busy_r;
  assign halted    = halted_r;
  assign retire    = retire_r;

endmodule
